pulse_generator: RTL and testbench
==================================

Name: pulse_generator

Overview:
- Programmable test-signal source in the clk_fs domain; produces a periodic rectangular waveform with programmable period and duty.
- This is the stimulus end of the frequency/duty measurement path: sig_out drives the measured-clock input of the cymometer, either in loopback or externally.
- Period is set in clk_fs cycles. Duty is an 8-bit fraction of 256, matching the pulse_width scale of the measurement side.
- New settings are taken through a valid/ready handshake and applied glitch-free at a period boundary.

Parameters:
- CLK_FS, 50_000_000: reference clock frequency in Hz. Informational only; used by benches to convert period to Hz.
- CNT_W, 32: width of the period and high-time counters.
- DUTY_W, 8: duty width; duty fraction = cfg_duty / 2^DUTY_W.
- MIN_PERIOD, 2: smallest accepted period in clk_fs cycles.

Ports:
- clk_fs  in  1  reference clock; the only clock in the block.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  run enable.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  block can accept a configuration.
- cfg_period  in  CNT_W  output period in clk_fs cycles.
- cfg_duty  in  DUTY_W  high fraction, in units of 1/256 for the default width.
- sig_out  out  1  generated waveform.
- period_start  out  1  one-cycle pulse in the first cycle of each period.
- cfg_err  out  1  one-cycle pulse when a configuration is rejected.
- active_period  out  CNT_W  period currently in force.
- active_high  out  CNT_W  high time currently in force.

Behaviour:
- Reset values: every output 0, cfg_ready 1, counter 0, FSM in IDLE.
- Reset asserted mid-operation clears all state immediately; any pending configuration is discarded.
- Configuration FSM has four states: IDLE, CALC1, CALC2, PEND.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready with cfg_period<MIN_PERIOD: cfg_err pulses the next cycle, the request is consumed, and the FSM stays in IDLE. Active settings are unchanged.
  - On a valid request: capture period and duty, go to CALC1.
- CALC1 -> CALC2: two-stage pipeline computes high = (period*duty) >> DUTY_W, with a full-width CNT_W+DUTY_W product.
- CALC2 -> PEND: clamp the result. If duty!=0 and high==0, force high=1. High is always < period because duty ≤ 255/256.
- PEND: wait for the apply point, then copy the pending values into active_period/active_high and go to IDLE.
- cfg_ready=0 in CALC1, CALC2 and PEND.
- Apply point, whichever occurs first:
  - the cycle in which the counter wraps (cnt==active_period-1 while running);
  - any cycle in which the generator is not running (en=0 or active_period==0).
- Running condition is en=1 and active_period!=0.
- Counter:
  - While running, cnt counts 0..active_period-1 and wraps.
  - While not running, cnt is held at 0.
- Outputs are registered and updated together with cnt:
  - sig_out=1 iff running and cnt<active_high.
  - period_start=1 iff running and cnt==0.
  - The first cycle of every period therefore shows period_start=1 and, if active_high>0, sig_out=1.
- en rising: the next cycle is cnt=0 with period_start=1.
- en falling: the next cycle has sig_out=0 and period_start=0.
- A configuration applied at a wrap takes effect from the new period's cnt=0. The old period always completes with its old high time; no runt pulses.
- duty=0: sig_out stays 0 and period_start keeps pulsing.
- No configuration yet applied: the block is idle regardless of en.
- cfg_valid while cfg_ready=0 is ignored. The requester holds cfg_valid until it sees ready.

Decomposition:
- Package pulse_gen_pkg holds:
  - CNT_W, DUTY_W and MIN_PERIOD defaults;
  - the FSM state enum (IDLE, CALC1, CALC2, PEND);
  - a cfg struct {period, high}.
- One sub-module, pg_duty_mult: a two-stage registered multiply with shift, inputs period/duty, output high. It is isolated so it can map to a DSP block.

Test Plan:
- Reset, then cfg period=10 duty=128, en=1: sig_out repeats 5 cycles high, 5 low; period_start every 10 cycles; active_period=10, active_high=5.
- cfg period=2 duty=1: the raw result 0 is clamped, giving active_high=1 and a waveform of 1 high, 1 low.
- cfg period=1 while the generator runs at 10/5: cfg_err pulses once, cfg_ready returns to 1, active values stay 10/5, and the waveform is uninterrupted.
- Running at 10/5, cfg period=20 duty=64 issued at cnt=3: the current period finishes as 5 high / 5 low; from the next cnt=0 the waveform is 5 high / 15 low.
- en dropped at cnt=2: sig_out=0 the next cycle. en re-raised: period_start and sig_out are both 1 on the first cycle.
- Running at 10/5, cfg duty=0 period=8: after the boundary, sig_out is constant 0 and period_start pulses every 8 cycles.
- rst asserted mid-CALC2: all outputs go to 0 at once. After release, en=1 gives no activity until a new configuration is applied.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared defaults and types for the pulse generator and its duty multiplier.
package pulse_gen_pkg;

  localparam int PG_CNT_W      = 32;
  localparam int PG_DUTY_W     = 8;
  localparam int PG_MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC1 = 2'd1,
    CALC2 = 2'd2,
    PEND  = 2'd3
  } pg_state_e;

  // One complete waveform setting: period and high time, both in clk_fs cycles.
  typedef struct packed {
    logic [PG_CNT_W-1:0] period;
    logic [PG_CNT_W-1:0] high;
  } pg_cfg_t;

endpackage

// File: rtl/pg_duty_mult.sv
// Two-stage registered high = (period * duty) >> DUTY_W, kept apart so it can map onto a DSP block.
module pg_duty_mult
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W  = PG_CNT_W,
  parameter int DUTY_W = PG_DUTY_W
) (
  input  logic              clk_fs,
  input  logic              rst,
  input  logic [CNT_W-1:0]  period,
  input  logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  high
);

  localparam int PROD_W = CNT_W + DUTY_W;

  logic [PROD_W-1:0] prod_q;
  logic [CNT_W-1:0]  high_q;

  // Full-width product so large periods never overflow before the shift.
  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      high_q <= '0;
    end else begin
      prod_q <= {{DUTY_W{1'b0}}, period} * {{CNT_W{1'b0}}, duty};
      high_q <= prod_q[PROD_W-1:DUTY_W];
    end
  end

  assign high = high_q;

endmodule

// File: rtl/pulse_generator.sv
// Programmable rectangular-wave source: period in clk_fs cycles, duty as a fraction of 2^DUTY_W,
// new settings accepted by handshake and switched in only at a period boundary.
module pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int CLK_FS     = 50_000_000,
  parameter int CNT_W      = PG_CNT_W,
  parameter int DUTY_W     = PG_DUTY_W,
  parameter int MIN_PERIOD = PG_MIN_PERIOD
) (
  input  logic              clk_fs,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [DUTY_W-1:0] cfg_duty,
  output logic              sig_out,
  output logic              period_start,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  active_period,
  output logic [CNT_W-1:0]  active_high
);

  // CLK_FS only documents the reference rate; a non-positive value is a wiring mistake.
  if (CLK_FS <= 0) begin : g_bad_clk_fs
  end

  // Handshake: a request transfers in the cycle where cfg_valid and cfg_ready are both 1;
  // the requester holds cfg_valid and its data stable until then, cfg_ready never depends on cfg_valid.

  pg_state_e         state;
  logic [CNT_W-1:0]  pend_period;
  logic [DUTY_W-1:0] pend_duty;
  logic [CNT_W-1:0]  pend_high;
  logic [CNT_W-1:0]  mult_high;
  logic [CNT_W-1:0]  cnt;

  logic accept;
  logic cfg_bad;
  logic running;
  logic wrap;
  logic apply;

  assign cfg_ready = (state == IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_bad   = (cfg_period < CNT_W'(MIN_PERIOD));
  assign running   = en && (active_period != '0);
  assign wrap      = running && (cnt == active_period - CNT_W'(1));
  assign apply     = (state == PEND) && (wrap || !running);

  // The multiplier samples the raw request, so its result lines up with CALC2.
  pg_duty_mult #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_duty_mult (
    .clk_fs (clk_fs),
    .rst    (rst),
    .period (cfg_period),
    .duty   (cfg_duty),
    .high   (mult_high)
  );

  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pend_period   <= '0;
      pend_duty     <= '0;
      pend_high     <= '0;
      cfg_err       <= 1'b0;
      active_period <= '0;
      active_high   <= '0;
    end else begin
      cfg_err <= accept && cfg_bad;
      case (state)
        IDLE: begin
          if (accept && !cfg_bad) begin
            pend_period <= cfg_period;
            pend_duty   <= cfg_duty;
            state       <= CALC1;
          end
        end
        CALC1: state <= CALC2;
        CALC2: begin
          // A nonzero duty must never collapse to a flat line.
          pend_high <= ((pend_duty != '0) && (mult_high == '0)) ? CNT_W'(1) : mult_high;
          state     <= PEND;
        end
        PEND: begin
          if (apply) begin
            active_period <= pend_period;
            active_high   <= pend_high;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs describe the cnt value held before each edge, so the first
  // registered cycle after a wrap or an en rise shows cnt == 0.
  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      sig_out      <= 1'b0;
      period_start <= 1'b0;
    end else if (running) begin
      cnt          <= wrap ? '0 : cnt + CNT_W'(1);
      sig_out      <= (cnt < active_high);
      period_start <= (cnt == '0);
    end else begin
      cnt          <= '0;
      sig_out      <= 1'b0;
      period_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_generator.sv
// Self-checking bench for pulse_generator: directed scenarios plus random traffic against a waveform-queue model.
module tb_pulse_generator;
  import pulse_gen_pkg::*;

  logic        clk_fs = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_period = '0;
  logic [7:0]  cfg_duty = '0;
  logic        cfg_ready;
  logic        sig_out;
  logic        period_start;
  logic        cfg_err;
  logic [31:0] active_period;
  logic [31:0] active_high;

  int tests = 0;
  int fails = 0;

  // Reference model: settings in force, one pending setting with its remaining latency,
  // and the rest of the current period as a queue of {sig_out, period_start} pairs.
  pg_cfg_t    act;
  pg_cfg_t    pend_cfg;
  bit         pend;
  int         pend_wait;
  logic [1:0] exp_q[$];
  logic       e_sig;
  logic       e_start;
  logic       e_err;
  bit         m_accept;

  pulse_generator dut (
    .clk_fs        (clk_fs),
    .rst           (rst),
    .en            (en),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_period    (cfg_period),
    .cfg_duty      (cfg_duty),
    .sig_out       (sig_out),
    .period_start  (period_start),
    .cfg_err       (cfg_err),
    .active_period (active_period),
    .active_high   (active_high)
  );

  always #5 clk_fs = ~clk_fs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] duty_high(input logic [31:0] p, input logic [7:0] d);
    longint unsigned h;
    h = (longint'(p) * longint'(d)) / 256;
    if (d != 0 && h == 0) h = 1;
    return h[31:0];
  endfunction

  task automatic model_reset();
    act = '0;
    pend_cfg = '0;
    pend = 0;
    pend_wait = 0;
    exp_q.delete();
    e_sig = 0;
    e_start = 0;
    e_err = 0;
    m_accept = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit running;
    bit ready_now;
    bit do_apply;
    logic [1:0] w;
    running = en && (act.period != 0);
    ready_now = pend && (pend_wait == 0);
    do_apply = 0;
    m_accept = 0;
    if (!running) begin
      e_sig = 0;
      e_start = 0;
      exp_q.delete();
      do_apply = ready_now;
    end else begin
      if (exp_q.size() == 0)
        for (int i = 0; i < int'(act.period); i++)
          exp_q.push_back({1'(i < int'(act.high)), 1'(i == 0)});
      w = exp_q.pop_front();
      e_sig = w[1];
      e_start = w[0];
      do_apply = ready_now && (exp_q.size() == 0);
    end
    e_err = 0;
    if (pend) begin
      if (do_apply) begin
        act = pend_cfg;
        pend = 0;
      end else if (pend_wait > 0) begin
        pend_wait--;
      end
    end else if (cfg_valid) begin
      m_accept = 1;
      if (cfg_period < 2) begin
        e_err = 1;
      end else begin
        pend = 1;
        pend_wait = 2;
        pend_cfg.period = cfg_period;
        pend_cfg.high = duty_high(cfg_period, cfg_duty);
      end
    end
  endtask

  task automatic compare_all();
    check("sig_out", 32'(sig_out), 32'(e_sig));
    check("period_start", 32'(period_start), 32'(e_start));
    check("cfg_err", 32'(cfg_err), 32'(e_err));
    check("cfg_ready", 32'(cfg_ready), 32'(!pend));
    check("active_period", active_period, act.period);
    check("active_high", active_high, act.high);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_fs);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_cfg(input logic [31:0] p, input logic [7:0] d);
    int n;
    n = 0;
    cfg_valid = 1;
    cfg_period = p;
    cfg_duty = d;
    do begin
      tick();
      n++;
    end while (!m_accept && n < 300);
    cfg_valid = 0;
    cfg_period = $urandom;
    cfg_duty = 8'($urandom);
    check("cfg_accept_bound", 32'(m_accept), 32'd1);
  endtask

  // Run until the cycle just observed corresponds to counter value c of the current period.
  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    while (!(exp_q.size() == int'(act.period) - 1 - c && act.period != 0) && n < 200) begin
      tick();
      n++;
    end
    check("wait_cnt_bound", 32'(exp_q.size()), 32'(int'(act.period) - 1 - c));
  endtask

  initial begin
    model_reset();
    rst = 1;
    @(posedge clk_fs);
    #1;
    compare_all();
    @(posedge clk_fs);
    #1;
    compare_all();
    rst = 0;

    // No setting applied yet: idle even with en high.
    en = 1;
    ticks(5);

    send_cfg(32'd10, 8'd128);
    ticks(32);

    // Rejected request while running.
    send_cfg(32'd1, 8'd77);
    ticks(15);
    send_cfg(32'd0, 8'd10);
    ticks(5);

    // Retune mid-period.
    wait_cnt(3);
    send_cfg(32'd20, 8'd64);
    ticks(45);

    send_cfg(32'd10, 8'd128);
    ticks(25);

    // en drop and restart.
    wait_cnt(2);
    en = 0;
    ticks(4);
    en = 1;
    ticks(15);

    send_cfg(32'd8, 8'd0);
    ticks(30);

    send_cfg(32'd2, 8'd1);
    ticks(10);

    send_cfg(32'd3, 8'd255);
    ticks(12);

    // Wide product, applied while stopped.
    en = 0;
    send_cfg(32'hF000_0000, 8'd200);
    ticks(5);
    send_cfg(32'd7, 8'd100);
    ticks(4);
    en = 1;
    ticks(20);

    // Reset while the new setting sits in CALC2.
    send_cfg(32'd12, 8'd50);
    tick();
    rst = 1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk_fs);
    #1;
    compare_all();
    rst = 0;
    ticks(20);

    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) en = ($urandom_range(0, 4) != 0);
      if (r >= 2 && r < 6) begin
        if ($urandom_range(0, 4) == 0) send_cfg(32'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        else send_cfg(32'($urandom_range(2, 24)), 8'($urandom_range(0, 255)));
      end
      ticks($urandom_range(1, 20));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
